// File: rtl/shading_pkg.sv
// Shared definitions for the shading-map region-fill engine.
package shading_pkg;

    // 2-bit pixel codes held across the lsb/msb bitplanes
    localparam logic [1:0] PIX_EMPTY  = 2'b00;
    localparam logic [1:0] PIX_SHADED = 2'b01;
    localparam logic [1:0] PIX_LINE   = 2'b10;
    localparam logic [1:0] PIX_BORDER = 2'b11;

    // Run modes
    localparam logic [1:0] MODE_NOP         = 2'd0;
    localparam logic [1:0] MODE_FILL_LINE   = 2'd1;
    localparam logic [1:0] MODE_FILL_BORDER = 2'd2;
    localparam logic [1:0] MODE_ERASE       = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_SCAN,
        ST_WB,
        ST_DONE
    } state_e;

    // True when the pixel is the edge code for the given fill mode
    function automatic logic is_boundary(input logic [1:0] mode, input logic [1:0] pix);
        return ((mode == MODE_FILL_LINE)   && (pix == PIX_LINE)) ||
               ((mode == MODE_FILL_BORDER) && (pix == PIX_BORDER));
    endfunction

endpackage

// File: rtl/fill_row_scanner.sv
// One-row parity scanner: shifts the work row right one pixel per step,
// inserting the processed pixel at the top, so after WIDTH steps the work
// row is back in its original bit order.
module fill_row_scanner
    import shading_pkg::*;
#(
    parameter int unsigned WIDTH = 800
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] rd_lsb_i,
    input  logic [WIDTH-1:0] rd_msb_i,
    output logic [WIDTH-1:0] orig_lsb_o,
    output logic [WIDTH-1:0] orig_msb_o,
    output logic [WIDTH-1:0] work_lsb_o,
    output logic [WIDTH-1:0] work_msb_o,
    output logic             unclosed_o,
    output logic             changed_o
);

    logic [WIDTH-1:0] orig_lsb_q, orig_lsb_d, orig_msb_q, orig_msb_d;
    logic [WIDTH-1:0] work_lsb_q, work_lsb_d, work_msb_q, work_msb_d;
    logic             inside_q, inside_d, prev_q, prev_d, changed_q, changed_d;
    logic [1:0]       cur, nxt;
    logic             bnd;

    // Next-state: load a fresh row, or classify and rewrite the current pixel
    always_comb begin
        orig_lsb_d = orig_lsb_q;
        orig_msb_d = orig_msb_q;
        work_lsb_d = work_lsb_q;
        work_msb_d = work_msb_q;
        inside_d   = inside_q;
        prev_d     = prev_q;
        changed_d  = changed_q;
        cur        = {work_msb_q[0], work_lsb_q[0]};
        nxt        = cur;
        bnd        = is_boundary(mode_i, cur);
        if (load_i) begin
            orig_lsb_d = rd_lsb_i;
            orig_msb_d = rd_msb_i;
            work_lsb_d = rd_lsb_i;
            work_msb_d = rd_msb_i;
            inside_d   = 1'b0;
            prev_d     = 1'b0;
            changed_d  = 1'b0;
        end else if (step_i) begin
            if (mode_i == MODE_ERASE) begin
                if (cur == PIX_SHADED) begin
                    nxt       = PIX_EMPTY;
                    changed_d = 1'b1;
                end
            end else begin
                // A run of adjacent boundary pixels is a single edge
                if (bnd && !prev_q) begin
                    inside_d = !inside_q;
                end else if ((cur == PIX_EMPTY) && inside_q) begin
                    nxt       = PIX_SHADED;
                    changed_d = 1'b1;
                end
                prev_d = bnd;
            end
            work_lsb_d = {nxt[0], work_lsb_q[WIDTH-1:1]};
            work_msb_d = {nxt[1], work_msb_q[WIDTH-1:1]};
        end
    end

    // Row and flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            orig_lsb_q <= '0;
            orig_msb_q <= '0;
            work_lsb_q <= '0;
            work_msb_q <= '0;
            inside_q   <= 1'b0;
            prev_q     <= 1'b0;
            changed_q  <= 1'b0;
        end else begin
            orig_lsb_q <= orig_lsb_d;
            orig_msb_q <= orig_msb_d;
            work_lsb_q <= work_lsb_d;
            work_msb_q <= work_msb_d;
            inside_q   <= inside_d;
            prev_q     <= prev_d;
            changed_q  <= changed_d;
        end
    end

    assign orig_lsb_o = orig_lsb_q;
    assign orig_msb_o = orig_msb_q;
    assign work_lsb_o = work_lsb_q;
    assign work_msb_o = work_msb_q;
    assign unclosed_o = inside_q && ((mode_i == MODE_FILL_LINE) || (mode_i == MODE_FILL_BORDER));
    assign changed_o  = changed_q;

endmodule

// File: rtl/scanline_fill_engine.sv
// Row-sequential region-fill engine: FSM, row addressing and run counters.
module scanline_fill_engine
    import shading_pkg::*;
#(
    parameter int unsigned WIDTH  = 800,
    parameter int unsigned ROWS   = 768,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] row_first,
    input  logic [ADDR_W-1:0] row_last,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data_lsb,
    input  logic [WIDTH-1:0]  rd_data_msb,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data_lsb,
    output logic [WIDTH-1:0]  wr_data_msb,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   rows_filled,
    output logic [ADDR_W:0]   rows_open
);

    localparam int unsigned WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned PCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CW  = ADDR_W + 1;

    if ((1 << ADDR_W) < ROWS) begin : g_geom_check
        $error("ADDR_W too narrow to address ROWS rows");
    end

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] row_q, row_d, last_q, last_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [PCW-1:0]    pcnt_q, pcnt_d;
    logic [CW-1:0]     filled_q, filled_d, open_q, open_d;
    logic              load, step, unclosed, changed;
    logic [WIDTH-1:0]  orig_lsb, orig_msb, work_lsb, work_msb;

    fill_row_scanner #(.WIDTH(WIDTH)) u_scanner (
        .clk_i      (clk),
        .rst_ni     (clear_n),
        .load_i     (load),
        .step_i     (step),
        .mode_i     (mode_q),
        .rd_lsb_i   (rd_data_lsb),
        .rd_msb_i   (rd_data_msb),
        .orig_lsb_o (orig_lsb),
        .orig_msb_o (orig_msb),
        .work_lsb_o (work_lsb),
        .work_msb_o (work_msb),
        .unclosed_o (unclosed),
        .changed_o  (changed)
    );

    // Next-state, scanner strobes and counter updates
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        row_d    = row_q;
        last_d   = last_q;
        wcnt_d   = wcnt_q;
        pcnt_d   = pcnt_q;
        filled_d = filled_q;
        open_d   = open_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    filled_d = '0;
                    open_d   = '0;
                    if ((mode == MODE_NOP) || (row_first > row_last)) begin
                        state_d = ST_DONE;
                    end else begin
                        mode_d  = mode;
                        row_d   = row_first;
                        last_d  = row_last;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                wcnt_d  = WCW'(RD_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    load    = 1'b1;
                    pcnt_d  = '0;
                    state_d = ST_SCAN;
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end
            ST_SCAN: begin
                step = 1'b1;
                if (pcnt_q == PCW'(WIDTH - 1)) begin
                    state_d = ST_WB;
                end else begin
                    pcnt_d = pcnt_q + PCW'(1);
                end
            end
            ST_WB: begin
                if (unclosed) begin
                    open_d = open_q + CW'(1);
                end else if (changed) begin
                    filled_d = filled_q + CW'(1);
                end
                if (row_q == last_q) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + ADDR_W'(1);
                    state_d = ST_RD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, latched run parameters and counters
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_NOP;
            row_q    <= '0;
            last_q   <= '0;
            wcnt_q   <= '0;
            pcnt_q   <= '0;
            filled_q <= '0;
            open_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            row_q    <= row_d;
            last_q   <= last_d;
            wcnt_q   <= wcnt_d;
            pcnt_q   <= pcnt_d;
            filled_q <= filled_d;
            open_q   <= open_d;
        end
    end

    // Outputs decode straight from state so reset clears them at once
    assign rd_en       = (state_q == ST_RD);
    assign rd_addr     = rd_en ? row_q : '0;
    assign wr_en       = (state_q == ST_WB);
    assign wr_addr     = wr_en ? row_q : '0;
    assign wr_data_lsb = !wr_en ? '0 : (unclosed ? orig_lsb : work_lsb);
    assign wr_data_msb = !wr_en ? '0 : (unclosed ? orig_msb : work_msb);
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign rows_filled = filled_q;
    assign rows_open   = open_q;

endmodule

// File: tb/tb_scanline_fill_engine.sv
// Directed bench for scanline_fill_engine with a 16-pixel, 1-cycle-latency RAM model.
module tb_scanline_fill_engine;

    localparam int unsigned W  = 16;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] row_first = '0;
    logic [AW-1:0] row_last = '0;
    logic          rd_en, wr_en, busy, done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0]  rd_data_lsb, rd_data_msb, wr_data_lsb, wr_data_msb;
    logic [AW:0]   rows_filled, rows_open;

    // RAM model and activity monitors
    logic [W-1:0]  mem_lsb [0:15];
    logic [W-1:0]  mem_msb [0:15];
    logic          ld_en = 1'b0;
    logic [3:0]    ld_row = '0;
    logic [W-1:0]  ld_lsb = '0, ld_msb = '0;
    logic          cnt_clr = 1'b0;
    int            rd_cnt = 0, wr_cnt = 0, clash_cnt = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [W-1:0]  last_wr_lsb = '0, last_wr_msb = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scanline_fill_engine #(.WIDTH(W), .ROWS(16), .ADDR_W(AW), .RD_LAT(1)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .start       (start),
        .mode        (mode),
        .row_first   (row_first),
        .row_last    (row_last),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data_lsb (rd_data_lsb),
        .rd_data_msb (rd_data_msb),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data_lsb (wr_data_lsb),
        .wr_data_msb (wr_data_msb),
        .busy        (busy),
        .done        (done),
        .rows_filled (rows_filled),
        .rows_open   (rows_open)
    );

    always @(posedge clk) begin
        if (ld_en) begin
            mem_lsb[ld_row] <= ld_lsb;
            mem_msb[ld_row] <= ld_msb;
        end
        if (rd_en) begin
            rd_data_lsb <= mem_lsb[rd_addr[3:0]];
            rd_data_msb <= mem_msb[rd_addr[3:0]];
        end
        if (wr_en) begin
            mem_lsb[wr_addr[3:0]] <= wr_data_lsb;
            mem_msb[wr_addr[3:0]] <= wr_data_msb;
            last_wr_addr <= wr_addr;
            last_wr_lsb  <= wr_data_lsb;
            last_wr_msb  <= wr_data_msb;
        end
        if (rd_en && wr_en) clash_cnt <= clash_cnt + 1;
        if (cnt_clr) begin
            rd_cnt <= 0;
            wr_cnt <= 0;
        end else begin
            if (rd_en) rd_cnt <= rd_cnt + 1;
            if (wr_en) wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [3:0] r, input logic [W-1:0] l, input logic [W-1:0] m);
        @(negedge clk);
        ld_en = 1'b1; ld_row = r; ld_lsb = l; ld_msb = m;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Start a run, wait (bounded) for done and check latency; optionally poke start mid-run
    task automatic run(input logic [1:0] m, input logic [AW-1:0] f, input logic [AW-1:0] l,
                       input int exp_lat, input bit poke);
        int lat;
        bit seen;
        @(negedge clk);
        mode = m; row_first = f; row_last = l; start = 1'b1; cnt_clr = 1'b1;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 500) begin
            @(negedge clk);
            start = 1'b0; cnt_clr = 1'b0;
            lat++;
            if (lat == 1) check_eq("busy_after_start", busy, (exp_lat > 1) ? 1 : 0);
            if (poke && lat == 5) begin
                start = 1'b1; mode = 2'd3; row_first = 0; row_last = 2;
            end
            if (done) seen = 1'b1;
        end
        check_eq("done_seen", seen, 1);
        check_eq("done_latency", lat, exp_lat);
        check_eq("busy_at_done", busy, 0);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
    endtask

    initial begin
        int n;
        bit wb_seen;
        repeat (3) @(negedge clk);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_counts", {rows_filled, rows_open}, 0);
        clear_n = 1'b1;

        preload(0, 16'h000D, 16'h0006);
        preload(1, 16'hFFFF, 16'h0000);
        preload(2, 16'hC000, 16'h4000);
        preload(3, 16'h0204, 16'h0204);
        preload(4, 16'h060C, 16'h060C);
        preload(5, 16'h0000, 16'h0020);
        for (int r = 6; r < 10; r++) preload(4'(r), '0, '0);
        preload(10, 16'h8001, 16'h8001);

        // Mode 2, borders at 2 and 9
        run(2'd2, 3, 3, 20, 1'b0);
        check_eq("t1_lsb", mem_lsb[3], 16'h03FC);
        check_eq("t1_msb", mem_msb[3], 16'h0204);
        check_eq("t1_filled", rows_filled, 1);
        check_eq("t1_open", rows_open, 0);
        check_eq("t1_wr_cnt", wr_cnt, 1);
        check_eq("t1_rd_cnt", rd_cnt, 1);
        check_eq("t1_wr_addr", last_wr_addr, 3);

        // Mode 2, border runs 2-3 and 9-10; start poked mid-run must be ignored
        run(2'd2, 4, 4, 20, 1'b1);
        check_eq("t2_lsb", mem_lsb[4], 16'h07FC);
        check_eq("t2_msb", mem_msb[4], 16'h060C);
        check_eq("t2_filled", rows_filled, 1);
        repeat (30) @(negedge clk);
        check_eq("t2_no_rerun_wr", wr_cnt, 1);
        check_eq("t2_idle_busy", busy, 0);

        // Mode 1, single line pixel: row left open
        run(2'd1, 5, 5, 20, 1'b0);
        check_eq("t3_wr_lsb", last_wr_lsb, 16'h0000);
        check_eq("t3_wr_msb", last_wr_msb, 16'h0020);
        check_eq("t3_wr_cnt", wr_cnt, 1);
        check_eq("t3_open", rows_open, 1);
        check_eq("t3_filled", rows_filled, 0);

        // Reversed range: immediate done, counters cleared
        run(2'd2, 5, 4, 1, 1'b0);
        check_eq("rev_rd_cnt", rd_cnt, 0);
        check_eq("rev_wr_cnt", wr_cnt, 0);
        check_eq("rev_open", rows_open, 0);

        // Mode 3 erase over rows 0..2
        run(2'd3, 0, 2, 58, 1'b0);
        check_eq("t4_r0_lsb", mem_lsb[0], 16'h0004);
        check_eq("t4_r0_msb", mem_msb[0], 16'h0006);
        check_eq("t4_r1_lsb", mem_lsb[1], 16'h0000);
        check_eq("t4_r2_lsb", mem_lsb[2], 16'h4000);
        check_eq("t4_r2_msb", mem_msb[2], 16'h4000);
        check_eq("t4_filled", rows_filled, 3);
        check_eq("t4_wr_cnt", wr_cnt, 3);
        check_eq("t4_rd_cnt", rd_cnt, 3);

        // Mode 0: immediate done, counters cleared
        run(2'd0, 0, 0, 1, 1'b0);
        check_eq("nop_rd_cnt", rd_cnt, 0);
        check_eq("nop_wr_cnt", wr_cnt, 0);
        check_eq("nop_filled", rows_filled, 0);

        // Reset asserted during the first write-back of a 4-row run
        @(negedge clk);
        mode = 2'd2; row_first = 6; row_last = 9; start = 1'b1; cnt_clr = 1'b1;
        wb_seen = 1'b0;
        n = 0;
        while (!wb_seen && n < 100) begin
            @(negedge clk);
            start = 1'b0; cnt_clr = 1'b0;
            n++;
            if (wr_en) wb_seen = 1'b1;
        end
        check_eq("rst_wb_reached", wb_seen, 1);
        clear_n = 1'b0;
        #1;
        check_eq("rst_wb_wr_en", wr_en, 0);
        check_eq("rst_wb_wr_data", wr_data_lsb | wr_data_msb, 0);
        check_eq("rst_wb_busy", busy, 0);
        check_eq("rst_wb_done", done, 0);
        @(negedge clk);
        clear_n = 1'b1;
        check_eq("rst_wb_dropped", wr_cnt, 0);

        // Normal run after reset
        run(2'd2, 10, 10, 20, 1'b0);
        check_eq("post_lsb", mem_lsb[10], 16'hFFFF);
        check_eq("post_msb", mem_msb[10], 16'h8001);
        check_eq("post_filled", rows_filled, 1);

        check_eq("rd_wr_clash", clash_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
